imm_decode_skid_ctrl: RTL and testbench

//  Decode-stage immediate sequencer between fetch and execute in the RISC-V pipeline.
//  - Accepts {pc, instr} beats on a valid/ready handshake.
//  - Extracts and sign-extends the I/S/B/U/J immediate and computes the pc-relative target.
//  - Buffers results in a 2-entry skid FIFO, so a backpressure stall from execute never

---
 rtl/imm_decode_skid_ctrl_if.sv | 51 +++++
 rtl/imm_decode_skid_ctrl.sv | 144 ++++++++++++++
 tb/tb_imm_decode_skid_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_skid_ctrl_if.sv
// Fetch-to-execute handshake bundle for the decode immediate sequencer.
// slave is the decode block, master is the fetch/execute side.
interface imm_decode_skid_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] in_pc_i;
  logic [XLEN-1:0] in_instr_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [XLEN-1:0] out_instr_o;
  logic [XLEN-1:0] out_imm_o;
  logic [XLEN-1:0] out_target_o;
  logic [2:0]      out_type_o;
  logic            out_illegal_o;

  modport slave (
    input  in_valid_i,
    input  in_pc_i,
    input  in_instr_i,
    input  flush_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_pc_o,
    output out_instr_o,
    output out_imm_o,
    output out_target_o,
    output out_type_o,
    output out_illegal_o
  );

  modport master (
    output in_valid_i,
    output in_pc_i,
    output in_instr_i,
    output flush_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_pc_o,
    input  out_instr_o,
    input  out_imm_o,
    input  out_target_o,
    input  out_type_o,
    input  out_illegal_o
  );
endinterface

// File: rtl/imm_decode_skid_ctrl.sv
// Decode-stage immediate former with a 2-entry skid FIFO.
// Outputs come straight from entry registers; ready is registered.
module imm_decode_skid_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  imm_decode_skid_ctrl_if.slave bus
);
  if (DEPTH != 2) begin : g_bad_depth
    $error("imm_decode_skid_ctrl: DEPTH must be 2");
  end

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_I    = 3'd1,
    T_S    = 3'd2,
    T_B    = 3'd3,
    T_U    = 3'd4,
    T_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    imm_type_e       typ;
    logic            illegal;
  } ent_t;

  ent_t       ent_q [2];
  ent_t       dec;
  ent_t       head;
  logic       rd_q;
  logic       wr_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       rdy_q;
  logic       push;
  logic       pop;
  logic [6:0] op;
  logic [XLEN-1:0] i;
  logic       is_i;
  logic       is_s;
  logic       is_b;
  logic       is_u;
  logic       is_j;

  always_comb begin
    i    = bus.in_instr_i;
    op   = i[6:0];
    is_i = op inside {7'b0000011, 7'b0010011,
                      7'b1100111};
    is_s = (op == 7'b0100011);
    is_b = (op == 7'b1100011);
    is_u = op inside {7'b0110111, 7'b0010111};
    is_j = (op == 7'b1101111);
  end

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc_i;
    dec.instr   = i;
    dec.typ     = T_NONE;
    dec.illegal = 1'b0;
    unique case (1'b1)
      is_i: begin
        dec.imm = {{20{i[31]}}, i[31:20]};
        dec.typ = T_I;
      end
      is_s: begin
        dec.imm = {{20{i[31]}}, i[31:25],
                   i[11:7]};
        dec.typ = T_S;
      end
      is_b: begin
        dec.imm = {{19{i[31]}}, i[31], i[7],
                   i[30:25], i[11:8], 1'b0};
        dec.typ = T_B;
      end
      is_u: begin
        dec.imm = {i[31:12], 12'b0};
        dec.typ = T_U;
      end
      is_j: begin
        dec.imm = {{11{i[31]}}, i[31],
                   i[19:12], i[20],
                   i[30:21], 1'b0};
        dec.typ = T_J;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.target = dec.pc + dec.imm;
  end

  assign push = bus.in_valid_i & rdy_q
              & ~bus.flush_i;
  assign pop  = (cnt_q != 2'd0)
              & bus.out_ready_i & ~bus.flush_i;

  always_comb begin
    cnt_d = cnt_q + {1'b0, push}
                  - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < 2; k++) begin
        ent_q[k] <= '0;
      end
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
      rdy_q <= 1'b1;
    end else if (bus.flush_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
      rdy_q <= 1'b1;
    end else begin
      if (push) begin
        ent_q[wr_q] <= dec;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != 2'd2);
    end
  end

  assign head              = ent_q[rd_q];
  assign bus.in_ready_o    = rdy_q;
  assign bus.out_valid_o   = (cnt_q != 2'd0);
  assign bus.out_pc_o      = head.pc;
  assign bus.out_instr_o   = head.instr;
  assign bus.out_imm_o     = head.imm;
  assign bus.out_target_o  = head.target;
  assign bus.out_type_o    = head.typ;
  assign bus.out_illegal_o = head.illegal;
endmodule

// File: tb/tb_imm_decode_skid_ctrl.sv
// Bench for imm_decode_skid_ctrl: queue model plus directed literals.
module tb_imm_decode_skid_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_decode_skid_ctrl_if #(.XLEN(32)) bus ();

  imm_decode_skid_ctrl #(
    .XLEN (32),
    .DEPTH(2)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] target;
    logic [31:0] typ;
    logic [31:0] ill;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               n, act, exp);
    end
  endtask

  function automatic logic [31:0] sx(
      input logic [31:0] v, input int bits);
    logic [31:0] half;
    half = 32'd1 << (bits - 1);
    if ((v & half) != 0)
      return v - (half << 1);
    return v;
  endfunction

  function automatic exp_t model(
      input logic [31:0] pc,
      input logic [31:0] ins);
    exp_t e;
    logic [31:0] v;
    e.pc    = pc;
    e.instr = ins;
    e.ill   = 0;
    e.imm   = 0;
    e.typ   = 0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin
        v = 32'(ins[31:20]);
        e.imm = sx(v, 12);
        e.typ = 1;
      end
      7'h23: begin
        v = 32'({ins[31:25], ins[11:7]});
        e.imm = sx(v, 12);
        e.typ = 2;
      end
      7'h63: begin
        v = 32'({ins[31], ins[7], ins[30:25],
                 ins[11:8], 1'b0});
        e.imm = sx(v, 13);
        e.typ = 3;
      end
      7'h37, 7'h17: begin
        e.imm = ins & 32'hFFFF_F000;
        e.typ = 4;
      end
      7'h6F: begin
        v = 32'({ins[31], ins[19:12], ins[20],
                 ins[30:21], 1'b0});
        e.imm = sx(v, 21);
        e.typ = 5;
      end
      default: e.ill = 1;
    endcase
    e.target = pc + e.imm;
    return e;
  endfunction

  always @(posedge clk) begin
    bit pu;
    bit po;
    if (rst_n) begin
      if (bus.flush_i) begin
        q.delete();
      end else begin
        pu = bus.in_valid_i && (q.size() < 2);
        po = (q.size() > 0) && bus.out_ready_i;
        if (po) void'(q.pop_front());
        if (pu) q.push_back(model(bus.in_pc_i,
                                  bus.in_instr_i));
      end
    end
  end

  always @(negedge rst_n) q.delete();

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_in_ready", 32'(bus.in_ready_o),
          32'(q.size() < 2));
      chk("m_out_valid", 32'(bus.out_valid_o),
          32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("m_pc", bus.out_pc_o, q[0].pc);
        chk("m_instr", bus.out_instr_o,
            q[0].instr);
        chk("m_imm", bus.out_imm_o, q[0].imm);
        chk("m_target", bus.out_target_o,
            q[0].target);
        chk("m_type", 32'(bus.out_type_o),
            q[0].typ);
        chk("m_illegal", 32'(bus.out_illegal_o),
            q[0].ill);
      end
    end
  end

  task automatic send(input logic [31:0] pc,
                      input logic [31:0] ins);
    bit ok;
    bit acc;
    acc = 0;
    bus.in_valid_i = 1'b1;
    bus.in_pc_i    = pc;
    bus.in_instr_i = ins;
    for (int n = 0; n < 20 && !acc; n++) begin
      ok = bus.in_ready_o;
      @(posedge clk);
      #1;
      if (ok) acc = 1;
    end
    bus.in_valid_i = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout pc=0x%08h", pc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_until_ready();
    bit ok;
    bit acc;
    acc = 0;
    for (int n = 0; n < 20 && !acc; n++) begin
      ok = bus.in_ready_o;
      @(posedge clk);
      #1;
      if (ok) acc = 1;
    end
    bus.in_valid_i = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL hold_timeout");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_pc_i     = '0;
    bus.in_instr_i  = '0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready_o), 1);
    chk("rst_out_valid", 32'(bus.out_valid_o), 0);
    chk("rst_pc", bus.out_pc_o, 0);
    chk("rst_imm", bus.out_imm_o, 0);
    chk("rst_target", bus.out_target_o, 0);
    chk("rst_type", 32'(bus.out_type_o), 0);
    chk("rst_illegal", 32'(bus.out_illegal_o), 0);
    rst_n = 1'b1;
    idle(1);

    bus.out_ready_i = 1'b1;
    send(32'h100, 32'hFE00_0EE3);
    @(negedge clk);
    chk("beq_valid", 32'(bus.out_valid_o), 1);
    chk("beq_imm", bus.out_imm_o, 32'hFFFF_FFFC);
    chk("beq_target", bus.out_target_o, 32'hFC);
    chk("beq_type", 32'(bus.out_type_o), 3);

    send(32'h200, 32'h0040_006F);
    @(negedge clk);
    chk("jal_imm", bus.out_imm_o, 32'h4);
    chk("jal_target", bus.out_target_o, 32'h204);
    chk("jal_type", 32'(bus.out_type_o), 5);

    send(32'h300, 32'h1234_50B7);
    @(negedge clk);
    chk("lui_imm", bus.out_imm_o, 32'h1234_5000);
    chk("lui_type", 32'(bus.out_type_o), 4);

    send(32'h400, 32'hFE11_2E23);
    @(negedge clk);
    chk("sw_imm", bus.out_imm_o, 32'hFFFF_FFFC);
    chk("sw_target", bus.out_target_o, 32'h3FC);
    chk("sw_type", 32'(bus.out_type_o), 2);
    idle(2);

    bus.out_ready_i = 1'b0;
    send(32'h1000, 32'h0010_0093);
    @(negedge clk);
    chk("stall_ready1", 32'(bus.in_ready_o), 1);
    send(32'h1004, 32'hFFC1_2083);
    @(negedge clk);
    chk("stall_ready2", 32'(bus.in_ready_o), 0);
    bus.in_valid_i = 1'b1;
    bus.in_pc_i    = 32'h1008;
    bus.in_instr_i = 32'h0080_006F;
    idle(3);
    chk("stall_head", bus.out_pc_o, 32'h1000);
    chk("stall_held", 32'(bus.in_ready_o), 0);
    bus.out_ready_i = 1'b1;
    hold_until_ready();
    idle(4);
    chk("stall_drained", 32'(bus.out_valid_o), 0);

    send(32'h2000, 32'h0000_0093);
    for (int k = 1; k <= 10; k++) begin
      send(32'h2000 + 32'(4 * k),
           {12'(k), 20'h00093});
      @(negedge clk);
      chk("ss_ready", 32'(bus.in_ready_o), 1);
      chk("ss_head", bus.out_pc_o,
          32'h2000 + 32'(4 * k));
    end
    idle(2);

    bus.out_ready_i = 1'b0;
    send(32'h3000, 32'h0010_0093);
    send(32'h3004, 32'h0020_0093);
    bus.in_valid_i = 1'b1;
    bus.in_pc_i    = 32'hDEAD_0000;
    bus.in_instr_i = 32'h0030_0093;
    bus.flush_i    = 1'b1;
    idle(1);
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("fl_valid", 32'(bus.out_valid_o), 0);
    chk("fl_ready", 32'(bus.in_ready_o), 1);
    bus.out_ready_i = 1'b1;
    idle(3);
    chk("fl_empty", 32'(bus.out_valid_o), 0);

    bus.out_ready_i = 1'b0;
    send(32'h3100, 32'h0010_0093);
    bus.in_valid_i = 1'b1;
    bus.in_pc_i    = 32'hBEEF_0000;
    bus.flush_i    = 1'b1;
    idle(1);
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("fl1_valid", 32'(bus.out_valid_o), 0);

    send(32'h500, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("ill_valid", 32'(bus.out_valid_o), 1);
    chk("ill_type", 32'(bus.out_type_o), 0);
    chk("ill_flag", 32'(bus.out_illegal_o), 1);
    chk("ill_imm", bus.out_imm_o, 0);
    chk("ill_target", bus.out_target_o, 32'h500);
    send(32'h504, 32'h0010_0093);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid_o), 0);
    chk("arst_ready", 32'(bus.in_ready_o), 1);
    chk("arst_pc", bus.out_pc_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    bus.out_ready_i = 1'b1;
    send(32'h600, 32'h0040_006F);
    @(negedge clk);
    chk("post_target", bus.out_target_o, 32'h604);
    idle(3);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
